// File: rtl/uop_gate_seq.sv
// Self-test sequencer for a 2-input AND/NAND gate cell: sweeps x,y through 00..11, checks z/notz, counts mismatches.
// Optional first-failure logging is enabled with `define UOP_GATE_SEQ_LOG_EN (adds fail_valid/fail_vec).
module uop_gate_seq #(
    parameter int HOLD_CYCLES = 2,
    parameter int N_PASSES    = 1,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             x,
    output logic             y,
    input  logic             z,
    input  logic             notz,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef UOP_GATE_SEQ_LOG_EN
    ,
    output logic             fail_valid,
    output logic [1:0]       fail_vec
`endif
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0]       PASS_LAST = 4'(N_PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [3:0]       pass_cnt_q, pass_cnt_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic             x_q, x_d, y_q, y_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d, err_inc;
    logic             fv_q, fv_d;
    logic [1:0]       fvec_q, fvec_d;
    logic             sample, mismatch;
    logic [1:0]       vec_nxt;

    // A vector with both outputs wrong is still a single mismatch.
    assign mismatch = (z != (x_q & y_q)) || (notz != ~(x_q & y_q));
    assign sample   = (hold_cnt_q == HOLD_LAST);
    assign err_inc  = (mismatch && err_q != ERR_MAX) ? err_q + 1'b1 : err_q;
    assign vec_nxt  = vec_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        pass_cnt_d = pass_cnt_q;
        hold_cnt_d = hold_cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_d      = err_q;
        fv_d       = fv_q;
        fvec_d     = fvec_q;
        case (state_q)
            IDLE: begin
                x_d = 1'b0;
                y_d = 1'b0;
                if (start) begin
                    state_d    = DRIVE;
                    vec_d      = 2'd0;
                    pass_cnt_d = 4'd0;
                    hold_cnt_d = 8'd0;
                    err_d      = '0;
                    busy_d     = 1'b1;
                    pass_d     = 1'b0;
                    fv_d       = 1'b0;
                    fvec_d     = 2'd0;
                end
            end
            DRIVE: begin
                if (sample) begin
                    err_d      = err_inc;
                    hold_cnt_d = 8'd0;
                    vec_d      = vec_nxt;
                    if (mismatch && !fv_q) begin
                        fv_d   = 1'b1;
                        fvec_d = {x_q, y_q};
                    end
                    if (vec_q == 2'd3) pass_cnt_d = pass_cnt_q + 4'd1;
                    if (vec_q == 2'd3 && pass_cnt_q == PASS_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        x_d     = 1'b0;
                        y_d     = 1'b0;
                        pass_d  = (err_inc == '0);
                    end else begin
                        x_d = vec_nxt[1];
                        y_d = vec_nxt[0];
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            vec_q      <= 2'd0;
            pass_cnt_q <= 4'd0;
            hold_cnt_q <= 8'd0;
            x_q        <= 1'b0;
            y_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fv_q       <= 1'b0;
            fvec_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            pass_cnt_q <= pass_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fv_q       <= fv_d;
            fvec_q     <= fvec_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

`ifdef UOP_GATE_SEQ_LOG_EN
    assign fail_valid = fv_q;
    assign fail_vec   = fvec_q;
`else
    logic unused_log;
    assign unused_log = fv_q ^ fvec_q[0] ^ fvec_q[1];
`endif

endmodule

// File: tb/tb_uop_gate_seq.sv
// Scoreboard bench for uop_gate_seq: per-run expectations from a vector-level fault model, checked by a done-driven monitor.
module tb_uop_gate_seq;
    localparam int H    = 2;
    localparam int NP   = 3;
    localparam int EW   = 3;
    localparam int TOT  = 4 * H * NP;
    localparam int EMAX = (1 << EW) - 1;

    logic clk = 1'b0;
    logic reset, start;
    logic x, y, z, notz, busy, done, pass;
    logic [EW-1:0] err_count;
`ifdef UOP_GATE_SEQ_LOG_EN
    logic fail_valid;
    logic [1:0] fail_vec;
`endif
    logic [3:0] f_z, f_n;

    // Gate under test: fault masks indexed by the {x,y} vector flip the ideal outputs.
    assign z    = (x & y) ^ f_z[{x, y}];
    assign notz = ~(x & y) ^ f_n[{x, y}];

    uop_gate_seq #(.HOLD_CYCLES(H), .N_PASSES(NP), .ERR_W(EW)) dut (
        .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .z(z), .notz(notz),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef UOP_GATE_SEQ_LOG_EN
        , .fail_valid(fail_valid), .fail_vec(fail_vec)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [EW-1:0] err;
        logic          ok;
        logic          fv;
        logic [1:0]    fvec;
    } exp_t;

    exp_t sb[$];
    exp_t last = '0;
    int m_state = 0;
    int m_k = 0;

    function automatic exp_t predict();
        exp_t e;
        int bad = 0;
        int tot_err;
        e = '0;
        for (int v = 0; v < 4; v++) begin
            if (f_z[v] | f_n[v]) begin
                bad++;
                if (!e.fv) begin
                    e.fv   = 1'b1;
                    e.fvec = 2'(v);
                end
            end
        end
        tot_err = bad * NP;
        if (tot_err > EMAX) tot_err = EMAX;
        e.err = EW'(tot_err);
        e.ok  = (bad == 0);
        return e;
    endfunction

    // Run-level timing model: 0 idle, 1 sweeping (m_k cycles elapsed), 2 done cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0;
            m_k = 0;
            sb.delete();
            last = '0;
        end else begin
            case (m_state)
                0: if (start) begin
                    sb.push_back(predict());
                    m_state = 1;
                    m_k = 0;
                end
                1: begin
                    m_k++;
                    if (m_k == TOT) m_state = 2;
                end
                default: m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("done_timing", done, m_state == 2);
            if (m_state == 1) begin
                chk("busy_run", busy, 1);
                chk("xy_seq", {x, y}, (m_k / H) % 4);
            end else begin
                chk("busy_idle", busy, 0);
                chk("xy_idle", {x, y}, 0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    e = sb.pop_front();
                    chk("err_count", err_count, e.err);
                    chk("pass", pass, e.ok);
`ifdef UOP_GATE_SEQ_LOG_EN
                    chk("fail_valid", fail_valid, e.fv);
                    if (e.fv) chk("fail_vec", fail_vec, e.fvec);
`endif
                    last = e;
                end
            end
            if (m_state == 0) begin
                chk("err_hold", err_count, last.err);
                chk("pass_hold", pass, last.ok);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (m_state != 0 && n < 4 * TOT) begin
            @(negedge clk);
            n++;
        end
        chk("run_timeout", m_state, 0);
        @(negedge clk);
    endtask

    task automatic run(input logic [3:0] fz, input logic [3:0] fn, input int poke);
        f_z = fz;
        f_n = fn;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (poke > 0) begin
            repeat (poke - 1) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err_count, 0);
`ifdef UOP_GATE_SEQ_LOG_EN
        chk({tag, "_fv"}, fail_valid, 0);
        chk({tag, "_fvec"}, fail_vec, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        f_z = 4'b0;
        f_n = 4'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        run(4'b0000, 4'b0000, 0);
        run(4'b1000, 4'b0000, 0);
        run(4'b0111, 4'b0111, 0);
        run(4'b0000, 4'b0000, 3);
        run(4'b0010, 4'b0100, 0);

        // Reset in the middle of a clock cycle, part way into a run with faults.
        f_z = 4'b1000;
        f_n = 4'b0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run(4'b0000, 4'b0000, 0);

        // start held high through back-to-back runs.
        f_z = 4'b0100;
        f_n = 4'b0000;
        start = 1'b1;
        repeat (2 * (TOT + 2)) @(negedge clk);
        start = 1'b0;
        wait_idle();

        for (int i = 0; i < 20; i++) begin
            run(4'($urandom), ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TOT + 2)) : 0);
        end
        run(4'b0000, 4'b0000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
